sdram_frame_arbiter: RTL and testbench
======================================

# sdram_frame_arbiter

Shares the single 32-bit SDRAM controller port between the camera frame writer (write requester) and the video output frame reader (read requester). Each granted request is serviced as one fixed-length Avalon-MM burst. Urgent reads take priority, ties alternate, and a skip counter bounds write starvation. The block sits between the camera/VIP frame-buffer logic and the SDRAM controller slave in the Qsys fabric.

## Interface
- ADDR_W, 25, word address width
- DATA_W, 32, data width
- BURST_LEN, 8, beats per burst (2..15)
- MAX_SKIP, 4, consecutive urgent-read wins over a pending write before the write is forced
- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous reset, active-high
- wr_req  in  1  write burst request; held until wr_grant
- wr_addr  in  ADDR_W  burst start word address; valid with wr_req
- wr_data  in  DATA_W  current write beat; advanced by requester on wr_data_take
- wr_grant  out  1  one-cycle pulse: write burst accepted
- wr_data_take  out  1  current wr_data beat consumed this cycle
- rd_req  in  1  read burst request; held until rd_grant
- rd_addr  in  ADDR_W  burst start word address
- rd_urgent  in  1  reader FIFO low; read preferred
- rd_grant  out  1  one-cycle pulse: read burst accepted
- rd_data  out  DATA_W  returned read beat
- rd_data_valid  out  1  rd_data valid this cycle
- m_address  out  ADDR_W  Avalon master address
- m_burstcount  out  4  constant BURST_LEN while m_read/m_write is high, else 0
- m_write, m_read  out  1  Avalon commands
- m_writedata  out  DATA_W  equals wr_data
- m_waitrequest  in  1
- m_readdata  in  DATA_W
- m_readdatavalid  in  1
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WR_BURST, RD_CMD, RD_WAIT.
- Arbitration runs in IDLE on every edge:
  - If wr_req and skip_cnt == MAX_SKIP, pick write.
  - Else if rd_req and rd_urgent, pick read.
  - Else if both are requesting, pick the opposite of last_grant.
  - Else pick whichever is requesting.
  - With no request, stay in IDLE.
- On a pick: latch the address into m_address, pulse the matching grant, update last_grant, and go to WR_BURST or RD_CMD.
- skip_cnt:
  - +1 (saturating at MAX_SKIP) when a read wins while wr_req is high.
  - Cleared when a write is granted.
  - Unchanged otherwise.
- WR_BURST:
  - m_write=1 and m_writedata=wr_data.
  - A beat is accepted when m_write and !m_waitrequest; wr_data_take equals that condition, combinationally, in the same cycle.
  - beat_cnt counts accepted beats. On the BURST_LEN-th accepted beat, go to IDLE.
  - m_address is held for the whole burst.
- RD_CMD:
  - m_read=1 until !m_waitrequest, then go to RD_WAIT.
  - m_readdatavalid arriving in the same cycle as command acceptance is counted.
- RD_WAIT:
  - Each m_readdatavalid increments beat_cnt and is forwarded.
  - After BURST_LEN beats, go to IDLE.
- m_readdatavalid is ignored in IDLE and WR_BURST, and is not forwarded there.
- Requests dropped before grant are legal; no grant is issued for them.
- Address and burst arithmetic: no increment inside the block; the slave handles burst addressing. beat_cnt width is clog2(BURST_LEN+1).

## Timing
- Reset values:
  - State IDLE, skip_cnt=0, beat_cnt=0.
  - last_grant=read, so the first tie goes to write.
  - All outputs 0, including rd_data.
- Reset is asynchronous. Asserting it mid-burst returns everything to reset values immediately. The burst is abandoned; the requester re-requests after reset.
- Grant latency: a request sampled in IDLE at edge N gives grant=1 and the first command cycle in N..N+1. Grant and command are both registered and coincide.
- Write throughput: BURST_LEN cycles with no waitrequest. Next arbitration is at the edge after the last beat, so one IDLE cycle falls between bursts.
- Read return: rd_data and rd_data_valid are registered copies of m_readdata and m_readdatavalid, 1 cycle later.
- The last read beat's rd_data_valid appears one cycle after the state has already returned to IDLE. This is legal.
- The grant is a single-cycle pulse even if the request stays high. A request still high in IDLE afterwards is a new request.

## Test plan
- Write only, waitrequest=0, BURST_LEN=8, wr_addr=0x100:
  - grant at cycle 1.
  - m_write high for 8 cycles at 0x100, m_burstcount=8.
  - 8 wr_data_take pulses, then busy=0.
- Read only, waitrequest high 3 cycles, then 8 readdatavalid beats with gaps:
  - m_read held 4 cycles.
  - 8 rd_data_valid beats, each 1 cycle after its source, data matching.
  - Return to IDLE.
- wr_req and rd_req both held, non-urgent:
  - Grants alternate W, R, W, R starting with write.
- rd_urgent=1 continuously with wr_req held, MAX_SKIP=4:
  - Sequence R, R, R, R, W, R…; skip_cnt returns to 0 after the write.
- waitrequest toggling every other cycle during a write burst:
  - Exactly 8 wr_data_take pulses, each only on a !waitrequest cycle; burst lasts 16 cycles.
- reset_reset asserted after 3 accepted write beats:
  - All outputs 0 asynchronously, busy=0.
  - After release, a pending wr_req is re-granted with a full 8-beat burst.

Source files
------------

// File: rtl/sdram_frame_arbiter.sv
// rtl/sdram_frame_arbiter.sv - camera-write / video-read arbiter onto one Avalon-MM SDRAM burst port
module sdram_frame_arbiter #(
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8,
    parameter int MAX_SKIP  = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_grant,
    output logic              wr_data_take,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_urgent,
    output logic              rd_grant,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_burstcount,
    output logic              m_write,
    output logic              m_read,
    output logic [DATA_W-1:0] m_writedata,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    output logic              busy
);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int SKIP_W = $clog2(MAX_SKIP + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [SKIP_W-1:0] SKIP_MAX  = SKIP_W'(MAX_SKIP);
    localparam logic [3:0]        BURST_CNT = 4'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_WAIT} state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [SKIP_W-1:0] skip_cnt;
    logic              last_grant_rd;
    logic              pick_wr;
    logic              pick_rd;
    logic              beat_accept;
    logic              rd_beat;

    // Requester selection: starved write first, then urgent read, then alternate on a tie
    always_comb begin
        pick_wr = 1'b0;
        pick_rd = 1'b0;
        if (wr_req && skip_cnt == SKIP_MAX) begin
            pick_wr = 1'b1;
        end else if (rd_req && rd_urgent) begin
            pick_rd = 1'b1;
        end else if (wr_req && rd_req) begin
            pick_wr = last_grant_rd;
            pick_rd = !last_grant_rd;
        end else begin
            pick_wr = wr_req;
            pick_rd = rd_req;
        end
    end

    assign beat_accept  = m_write && !m_waitrequest;
    assign wr_data_take = beat_accept;
    assign m_writedata  = m_write ? wr_data : '0;
    assign m_burstcount = (m_write || m_read) ? BURST_CNT : 4'd0;
    assign busy         = (state != IDLE);
    // Read data belongs to us only once the command is accepted; stray beats elsewhere are dropped
    assign rd_beat      = m_readdatavalid &&
                          ((state == RD_WAIT) || (state == RD_CMD && !m_waitrequest));

    // Arbitration, burst sequencing and registered command/grant/return outputs
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            skip_cnt      <= '0;
            last_grant_rd <= 1'b1;
            wr_grant      <= 1'b0;
            rd_grant      <= 1'b0;
            m_address     <= '0;
            m_write       <= 1'b0;
            m_read        <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            wr_grant      <= 1'b0;
            rd_grant      <= 1'b0;
            rd_data_valid <= rd_beat;
            if (rd_beat) begin
                rd_data <= m_readdata;
            end
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (pick_wr) begin
                        m_address     <= wr_addr;
                        wr_grant      <= 1'b1;
                        m_write       <= 1'b1;
                        last_grant_rd <= 1'b0;
                        skip_cnt      <= '0;
                        state         <= WR_BURST;
                    end else if (pick_rd) begin
                        m_address     <= rd_addr;
                        rd_grant      <= 1'b1;
                        m_read        <= 1'b1;
                        last_grant_rd <= 1'b1;
                        if (wr_req && skip_cnt != SKIP_MAX) begin
                            skip_cnt <= skip_cnt + 1'b1;
                        end
                        state         <= RD_CMD;
                    end
                end
                WR_BURST: begin
                    if (beat_accept) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            m_write  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                RD_CMD: begin
                    if (!m_waitrequest) begin
                        m_read <= 1'b0;
                        state  <= RD_WAIT;
                    end
                    if (rd_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (rd_beat) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// tb/tb_sdram_frame_arbiter.sv - randomized self-checking bench for sdram_frame_arbiter
module tb_sdram_frame_arbiter;
    localparam int ADDR_W    = 25;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 8;
    localparam int MAX_SKIP  = 4;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_grant;
    logic              wr_data_take;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_urgent;
    logic              rd_grant;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic [ADDR_W-1:0] m_address;
    logic [3:0]        m_burstcount;
    logic              m_write;
    logic              m_read;
    logic [DATA_W-1:0] m_writedata;
    logic              m_waitrequest;
    logic [DATA_W-1:0] m_readdata;
    logic              m_readdatavalid;
    logic              busy;

    sdram_frame_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .MAX_SKIP(MAX_SKIP)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_grant(wr_grant), .wr_data_take(wr_data_take),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_urgent(rd_urgent),
        .rd_grant(rd_grant), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .m_address(m_address), .m_burstcount(m_burstcount),
        .m_write(m_write), .m_read(m_read), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .busy(busy)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: observed 0x%0h required 0x%0h at %0t", tag, actual, expected, $time);
    endtask

    // reference model: one burst in flight (kind 0 none, 1 write, 2 read)
    int kind, beats_left, skip, wcyc, ccyc, slave_pending;
    bit cmd_open, last_rd;
    logic [ADDR_W-1:0] cur_addr;
    // requesters
    bit wr_pend, rd_pend;
    logic [ADDR_W-1:0] wr_a, rd_a;
    int wr_id, act_id, wr_idx;
    bit take_seen;
    // expectations for the next sample point
    bit e_wg, e_rg, e_rdv;
    logic [DATA_W-1:0] e_rdd;
    // DUT-side observations
    int dut_wcyc, dut_rcyc, dut_takes, gcount;
    bit prev_mw, prev_mr;
    logic [63:0] gseq;
    // stimulus knobs
    int k_wr, k_rd, k_urg, k_wait, k_val, k_drop;
    bit k_fixaddr;

    function automatic logic [DATA_W-1:0] wdata(input int id, input int idx);
        return {id[15:0], 8'hA5, idx[7:0]};
    endfunction

    function automatic int arbitrate(input bit w, input bit r, input bit u);
        if (w && skip == MAX_SKIP) return 1;
        if (r && u) return 2;
        if (w && r) return last_rd ? 1 : 2;
        if (w) return 1;
        if (r) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        kind = 0; cmd_open = 0; beats_left = 0; skip = 0; last_rd = 1;
        slave_pending = 0; wcyc = 0; ccyc = 0;
        e_wg = 0; e_rg = 0; e_rdv = 0; e_rdd = '0; take_seen = 0;
        dut_wcyc = 0; dut_rcyc = 0; dut_takes = 0; prev_mw = 0; prev_mr = 0;
    endtask

    task automatic quiet_inputs();
        wr_req = 0; rd_req = 0; rd_urgent = 0; m_waitrequest = 0;
        m_readdatavalid = 0; m_readdata = '0;
    endtask

    task automatic check_zero(input string where);
        check_eq({where, "_wr_grant"}, wr_grant, 0);
        check_eq({where, "_rd_grant"}, rd_grant, 0);
        check_eq({where, "_wr_data_take"}, wr_data_take, 0);
        check_eq({where, "_rd_data"}, rd_data, 0);
        check_eq({where, "_rd_data_valid"}, rd_data_valid, 0);
        check_eq({where, "_m_address"}, m_address, 0);
        check_eq({where, "_m_burstcount"}, m_burstcount, 0);
        check_eq({where, "_m_write"}, m_write, 0);
        check_eq({where, "_m_read"}, m_read, 0);
        check_eq({where, "_m_writedata"}, m_writedata, 0);
        check_eq({where, "_busy"}, busy, 0);
    endtask

    task automatic set_knobs(input int w, input int r, input int u, input int wt, input int v, input int d);
        k_wr = w; k_rd = r; k_urg = u; k_wait = wt; k_val = v; k_drop = d;
    endtask

    task automatic step();
        int pick;
        bit real_valid;
        @(negedge clk_clk);
        check_eq("wr_grant", wr_grant, e_wg);
        check_eq("rd_grant", rd_grant, e_rg);
        check_eq("m_write", m_write, kind == 1);
        check_eq("m_read", m_read, kind == 2 && cmd_open);
        check_eq("busy", busy, kind != 0);
        check_eq("m_burstcount", m_burstcount, (kind == 1 || (kind == 2 && cmd_open)) ? BURST_LEN : 0);
        if (kind == 1 || (kind == 2 && cmd_open)) check_eq("m_address", m_address, cur_addr);
        check_eq("rd_data_valid", rd_data_valid, e_rdv);
        if (e_rdv) check_eq("rd_data", rd_data, e_rdd);

        if (wr_grant || rd_grant) begin
            gseq = {gseq[62:0], wr_grant};
            gcount++;
        end
        if (m_write) dut_wcyc++;
        if (m_read) dut_rcyc++;
        if (prev_mw && !m_write) begin
            check_eq("takes_per_burst", dut_takes, BURST_LEN);
            if (k_wait == 0) check_eq("write_burst_cycles", dut_wcyc, BURST_LEN);
            if (k_wait == 2) check_eq("write_burst_cycles_toggle", dut_wcyc, 2 * BURST_LEN);
            dut_wcyc = 0;
            dut_takes = 0;
        end
        if (prev_mr && !m_read) begin
            if (k_wait == 3) check_eq("read_cmd_cycles_wait3", dut_rcyc, 4);
            if (k_wait == 0) check_eq("read_cmd_cycles", dut_rcyc, 1);
            dut_rcyc = 0;
        end
        prev_mw = m_write;
        prev_mr = m_read;

        if (take_seen) wr_idx++;
        if (e_wg) begin wr_pend = 0; act_id = wr_id; wr_idx = 0; end
        if (e_rg) rd_pend = 0;

        if (wr_pend && $urandom_range(0, 99) < k_drop) wr_pend = 0;
        else if (!wr_pend && $urandom_range(0, 99) < k_wr) begin
            wr_pend = 1; wr_id++;
            wr_a = k_fixaddr ? ADDR_W'(32'h100) : ADDR_W'($urandom);
        end
        if (rd_pend && $urandom_range(0, 99) < k_drop) rd_pend = 0;
        else if (!rd_pend && $urandom_range(0, 99) < k_rd) begin
            rd_pend = 1;
            rd_a = ADDR_W'($urandom);
        end

        wr_req = wr_pend; wr_addr = wr_a; rd_req = rd_pend; rd_addr = rd_a;
        rd_urgent = (k_urg == 1) || (k_urg == 2 && $urandom_range(0, 1) == 1);
        wr_data = wdata(act_id, wr_idx);
        case (k_wait)
            1: m_waitrequest = ($urandom_range(0, 99) < 35);
            2: m_waitrequest = (kind == 1 && wcyc % 2 == 0);
            3: m_waitrequest = (kind == 2 && cmd_open && ccyc < 3);
            default: m_waitrequest = 1'b0;
        endcase

        if (kind == 2 && cmd_open && !m_waitrequest) slave_pending += BURST_LEN;
        real_valid = 0;
        if (slave_pending > 0) real_valid = ($urandom_range(0, 99) < k_val);
        m_readdatavalid = real_valid || (slave_pending == 0 && kind != 2 && $urandom_range(0, 99) < 10);
        m_readdata = $urandom;
        if (real_valid) slave_pending--;

        #1;
        check_eq("wr_data_take", wr_data_take, kind == 1 && !m_waitrequest);
        if (kind == 1) check_eq("m_writedata", m_writedata, wdata(act_id, BURST_LEN - beats_left));
        take_seen = wr_data_take;
        if (wr_data_take) dut_takes++;

        e_wg = 0; e_rg = 0; e_rdv = 0;
        case (kind)
            0: begin
                pick = arbitrate(wr_pend, rd_pend, rd_urgent);
                if (pick == 1) begin
                    e_wg = 1; kind = 1; beats_left = BURST_LEN; cur_addr = wr_a;
                    skip = 0; last_rd = 0; wcyc = 0;
                end else if (pick == 2) begin
                    e_rg = 1; kind = 2; cmd_open = 1; beats_left = BURST_LEN; cur_addr = rd_a;
                    if (wr_pend && skip < MAX_SKIP) skip++;
                    last_rd = 1; ccyc = 0;
                end
            end
            1: begin
                wcyc++;
                if (!m_waitrequest) begin
                    beats_left--;
                    if (beats_left == 0) kind = 0;
                end
            end
            default: begin
                if (cmd_open) begin
                    ccyc++;
                    if (!m_waitrequest) cmd_open = 0;
                end
                if (real_valid) begin
                    e_rdv = 1; e_rdd = m_readdata; beats_left--;
                    if (beats_left == 0) kind = 0;
                end
            end
        endcase
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int n = 0;
        k_wr = 0; k_rd = 0; k_drop = 0;
        while ((kind != 0 || wr_pend || rd_pend) && n < 300) begin
            step();
            n++;
        end
        check_eq("drain_in_budget", n < 300, 1);
        step();
        step();
    endtask

    task automatic pulse_reset(input string where);
        @(negedge clk_clk);
        reset_reset = 1;
        quiet_inputs();
        #1;
        check_zero(where);
        model_reset();
        wr_pend = 0; rd_pend = 0; gseq = '0; gcount = 0;
        @(negedge clk_clk);
        reset_reset = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        logic [ADDR_W-1:0] saved_addr;
        reset_reset = 1;
        quiet_inputs();
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        wr_pend = 0; rd_pend = 0; wr_a = '0; rd_a = '0;
        wr_id = 0; act_id = 0; wr_idx = 0; gseq = '0; gcount = 0; k_fixaddr = 0;
        set_knobs(0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk_clk);
        reset_reset = 0;

        // write only, no waitrequest, address 0x100
        k_fixaddr = 1;
        set_knobs(100, 0, 0, 0, 0, 0);
        run(40);
        drain();
        k_fixaddr = 0;

        // read only, command held off three cycles, gapped return beats
        set_knobs(0, 100, 0, 3, 50, 0);
        run(80);
        drain();

        // both requesting, never urgent: grants alternate starting with write
        pulse_reset("reset_alt");
        set_knobs(100, 100, 0, 0, 70, 0);
        run(150);
        check_eq("alt_grant_count", gcount >= 8, 1);
        if (gcount >= 8) check_eq("alt_sequence", (gseq >> (gcount - 8)) & 64'hFF, 64'hAA);
        drain();

        // urgent reads against a held write: four read wins then a forced write
        pulse_reset("reset_urg");
        set_knobs(100, 100, 1, 0, 100, 0);
        run(150);
        check_eq("urg_grant_count", gcount >= 10, 1);
        if (gcount >= 10) check_eq("urg_sequence", (gseq >> (gcount - 10)) & 64'h3FF, 64'h021);
        drain();

        // waitrequest toggling during write bursts
        set_knobs(100, 0, 0, 2, 0, 0);
        run(60);
        drain();

        // reset after three accepted write beats
        set_knobs(100, 0, 0, 0, 0, 0);
        n = 0;
        while (!(kind == 1 && beats_left == BURST_LEN - 3) && n < 60) begin
            step();
            n++;
        end
        check_eq("midburst_reached", n < 60, 1);
        saved_addr = cur_addr;
        @(posedge clk_clk);
        #2;
        reset_reset = 1;
        #1;
        check_zero("midburst_reset");
        model_reset();
        quiet_inputs();
        wr_pend = 1; wr_id++; wr_a = saved_addr; rd_pend = 0;
        @(negedge clk_clk);
        reset_reset = 0;
        set_knobs(0, 0, 0, 0, 0, 0);
        run(14);
        drain();

        // randomized mix with drops, waits, urgency and stray readdatavalid
        set_knobs(30, 30, 2, 1, 60, 5);
        run(1500);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
